encrypt_stage_3: RTL and testbench



---
 rtl/encrypt_stage_3.sv | 123 ++++++++++++
 tb/tb_encrypt_stage_3.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encrypt_stage_3.sv
`default_nettype none
// ============================================================================
// Module   : encrypt_stage_3
// Summary  : Keys 60-bit plaintext with an LFSR-derived additive mask and packs
//            {cipher, key, tag} frames through a 2-stage valid/ready pipeline.
//            Optional LFSR reseed port compiled in with ENC3_RESEED_EN.
// Revision : 1.0
// ============================================================================
module encrypt_stage_3 #(
   parameter logic [10:0] LFSR_SEED = 11'h001,
   parameter logic [10:0] LFSR_MASK = 11'h500
) (
   input  logic        Clk,
   input  logic        Rst,
`ifdef ENC3_RESEED_EN
   input  logic        seed_load,
   input  logic [10:0] seed_val,
`endif
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [59:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [77:0] out_data
);

   localparam logic [5:0] c_TAG_ONE = 6'd1;

   logic        r_s1_valid;
   logic [59:0] r_s1_pt;
   logic [10:0] r_s1_key;
   logic [5:0]  r_s1_tag;
   logic [10:0] r_lfsr;
   logic [5:0]  r_tag;
   logic        r_out_valid;
   logic [77:0] r_out_data;

   logic        w_s2_free;
   logic        w_accept;
   logic        w_s1_to_s2;
   logic [10:0] w_lfsr_adv;
   logic [10:0] w_lfsr_nxt;
   logic [5:0]  w_tag_nxt;
   logic [59:0] w_b;
   logic [60:0] w_x;
   logic [60:0] w_y;
   logic [77:0] w_frame;

   assign w_s2_free  = !r_out_valid || out_ready;
   assign in_ready   = !r_s1_valid || w_s2_free;
   assign w_accept   = in_valid && in_ready;
   assign w_s1_to_s2 = r_s1_valid && w_s2_free;

   // Galois step: shift right, fold the feedback mask in when bit 0 falls out
   assign w_lfsr_adv = {1'b0, r_lfsr[10:1]} ^ (r_lfsr[0] ? LFSR_MASK : 11'h000);

   always_comb begin
      w_lfsr_nxt = r_lfsr;
      w_tag_nxt  = r_tag;
      if (w_accept) begin
         w_lfsr_nxt = w_lfsr_adv;
         w_tag_nxt  = r_tag + c_TAG_ONE;
      end
`ifdef ENC3_RESEED_EN
      // Reseed overrides the advance; the word accepted now already holds the old key
      if (seed_load) begin
         w_lfsr_nxt = (seed_val == 11'h000) ? LFSR_SEED : seed_val;
         w_tag_nxt  = 6'd0;
      end
`endif
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_lfsr <= LFSR_SEED;
         r_tag  <= 6'd0;
      end else begin
         r_lfsr <= w_lfsr_nxt;
         r_tag  <= w_tag_nxt;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_s1_valid <= 1'b0;
         r_s1_pt    <= '0;
         r_s1_key   <= '0;
         r_s1_tag   <= '0;
      end else if (w_accept) begin
         r_s1_valid <= 1'b1;
         r_s1_pt    <= in_data;
         r_s1_key   <= r_lfsr;
         r_s1_tag   <= r_tag;
      end else if (w_s1_to_s2) begin
         r_s1_valid <= 1'b0;
      end
   end

   // Key expansion mask, alternating true and inverted copies of the key
   assign w_b = {r_s1_key[4:0], r_s1_key, ~r_s1_key, r_s1_key, r_s1_key, ~r_s1_key};

   // Even-parity bit sits below the plaintext; carry out of bit 60 is dropped
   assign w_x     = {r_s1_pt, ^r_s1_pt};
   assign w_y     = w_x + {1'b0, w_b};
   assign w_frame = {w_y, r_s1_key, r_s1_tag};

   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else if (w_s1_to_s2) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_frame;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_encrypt_stage_3.sv
`default_nettype none
// ============================================================================
// Module   : tb_encrypt_stage_3
// Summary  : Directed self-checking bench for encrypt_stage_3.
// Revision : 1.0
// ============================================================================
module tb_encrypt_stage_3;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        in_valid;
   logic        in_ready;
   logic [59:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [77:0] out_data;

   int errors = 0;
   int checks = 0;

   logic [10:0] m_lfsr;
   logic [5:0]  m_tag;

   encrypt_stage_3 #(.LFSR_SEED(11'h001), .LFSR_MASK(11'h500)) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [10:0] lfsr_step(input logic [10:0] s);
      return (s >> 1) ^ (s[0] ? 11'h500 : 11'h000);
   endfunction

   function automatic logic [59:0] key_mask(input logic [10:0] k);
      return {k[4:0], k, ~k, k, k, ~k};
   endfunction

   function automatic logic [77:0] model_frame(input logic [59:0] pt, input logic [10:0] k,
                                               input logic [5:0] t);
      logic [60:0] x;
      logic [60:0] y;
      x = {pt, ^pt};
      y = x + {1'b0, key_mask(k)};
      return {y, k, t};
   endfunction

   function automatic logic [59:0] recover(input logic [77:0] f);
      logic [60:0] d;
      d = f[77:17] - {1'b0, key_mask(f[16:6])};
      return d[60:1];
   endfunction

   task automatic apply_reset();
      Rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge Clk);
      #1;
      Rst    = 1'b0;
      m_lfsr = 11'h001;
      m_tag  = 6'd0;
   endtask

   // Pushes one word through an otherwise idle pipeline; lat counts cycles from
   // the accept cycle to the cycle out_valid is seen.
   task automatic xfer(input logic [59:0] pt, output logic [77:0] frame, output int lat,
                       output logic [77:0] exp);
      bit done;
      done  = 1'b0;
      frame = '0;
      lat   = 0;
      exp   = model_frame(pt, m_lfsr, m_tag);
      in_valid  = 1'b1;
      in_data   = pt;
      out_ready = 1'b1;
      for (int i = 0; i < 10 && !done; i++) begin
         @(negedge Clk);
         if (in_ready) done = 1'b1;
         @(posedge Clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) begin
         errors++; checks++;
         $display("FAIL xfer_accept: in_ready stayed 0 for 10 cycles");
         return;
      end
      m_lfsr = lfsr_step(m_lfsr);
      m_tag  = m_tag + 6'd1;
      lat  = 1;
      done = 1'b0;
      for (int i = 0; i < 10 && !done; i++) begin
         if (out_valid) begin
            done  = 1'b1;
            frame = out_data;
         end else begin
            @(posedge Clk);
            #1;
            lat++;
         end
      end
      if (!done) begin
         errors++; checks++;
         $display("FAIL xfer_output: out_valid never seen within 10 cycles");
         return;
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
      end
      checks++;
      if (out_data !== 78'h0) begin
         errors++; $display("FAIL reset_out_data: got %h want 0", out_data);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_first_words();
      logic [77:0] f;
      logic [77:0] e;
      int lat;
      xfer(60'h0, f, lat, e);
      checks++;
      if (lat !== 2) begin
         errors++; $display("FAIL first_latency: got %0d want 2", lat);
      end
      checks++;
      if (f !== {61'h0080_1FFC_0040_0FFE, 11'h001, 6'd0}) begin
         errors++; $display("FAIL first_frame: got %h want %h", f,
                            {61'h0080_1FFC_0040_0FFE, 11'h001, 6'd0});
      end
      xfer(60'h0AB_CDEF_0123_4567, f, lat, e);
      checks++;
      if (f[16:6] !== 11'h500 || f[5:0] !== 6'd1) begin
         errors++; $display("FAIL second_key_tag: got key %h tag %0d want 500 tag 1", f[16:6], f[5:0]);
      end
      checks++;
      if (f !== e) begin
         errors++; $display("FAIL second_frame: got %h want %h", f, e);
      end
      xfer(60'hFED_CBA9_8765_4321, f, lat, e);
      checks++;
      if (f[16:6] !== 11'h280 || f[5:0] !== 6'd2) begin
         errors++; $display("FAIL third_key_tag: got key %h tag %0d want 280 tag 2", f[16:6], f[5:0]);
      end
      checks++;
      if (recover(f) !== 60'hFED_CBA9_8765_4321) begin
         errors++; $display("FAIL third_recover: got %h want FEDCBA987654321", recover(f));
      end
   endtask

   task automatic test_carry();
      logic [77:0] f;
      logic [77:0] e;
      int lat;
      // All-ones plaintext: x = 2^61-2, so y wraps to b-2
      xfer(60'hFFF_FFFF_FFFF_FFFF, f, lat, e);
      checks++;
      if (f !== {61'h0014_0D7E_500A_06BD, 11'h140, 6'd3}) begin
         errors++; $display("FAIL carry_frame: got %h want %h", f,
                            {61'h0014_0D7E_500A_06BD, 11'h140, 6'd3});
      end
      checks++;
      if (recover(f) !== 60'hFFF_FFFF_FFFF_FFFF) begin
         errors++; $display("FAIL carry_recover: got %h want FFFFFFFFFFFFFFF", recover(f));
      end
      xfer(60'h123_4567_89AB_CDEF, f, lat, e);
      checks++;
      if (f !== e || f[16:6] !== 11'h0A0) begin
         errors++; $display("FAIL mixed_frame: got %h want %h", f, e);
      end
      checks++;
      if (recover(f) !== 60'h123_4567_89AB_CDEF) begin
         errors++; $display("FAIL mixed_recover: got %h want 123456789ABCDEF", recover(f));
      end
   endtask

   task automatic test_random_stream();
      logic [77:0] q[$];
      logic [77:0] held;
      logic [77:0] exp;
      logic [63:0] r64;
      bit stalled;
      int sent, got, cyc;
      stalled = 1'b0;
      held = '0;
      sent = 0; got = 0; cyc = 0;
      while (got < 200 && cyc < 5000) begin
         r64       = {$urandom(), $urandom()};
         in_valid  = (sent < 200) && ($urandom_range(0, 3) != 0);
         in_data   = r64[59:0];
         out_ready = ($urandom_range(0, 2) != 0);
         @(negedge Clk);
         checks++;
         if (in_ready !== !(q.size() == 2 && !out_ready)) begin
            errors++; $display("FAIL stream_in_ready: got %b with %0d in flight, out_ready %b",
                               in_ready, q.size(), out_ready);
         end
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== held) begin
               errors++; $display("FAIL stream_stall_hold: got %b/%h want 1/%h", out_valid, out_data, held);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL stream_extra: got %h want nothing", out_data);
            end else begin
               exp = q.pop_front();
               if (out_data !== exp) begin
                  errors++; $display("FAIL stream_data: got %h want %h", out_data, exp);
               end
            end
            got++;
         end
         if (in_valid && in_ready) begin
            q.push_back(model_frame(in_data, m_lfsr, m_tag));
            m_lfsr = lfsr_step(m_lfsr);
            m_tag  = m_tag + 6'd1;
            sent++;
         end
         stalled = out_valid && !out_ready;
         held    = out_data;
         @(posedge Clk);
         #1;
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (got != 200 || q.size() != 0) begin
         errors++; $display("FAIL stream_count: got %0d frames (%0d pending) want 200", got, q.size());
      end
   endtask

   task automatic test_back_to_back();
      logic [77:0] q[$];
      logic [77:0] exp;
      int sent, got, cyc;
      apply_reset();
      sent = 0; got = 0; cyc = 0;
      out_ready = 1'b1;
      while (got < 70 && cyc < 200) begin
         in_valid = (sent < 70);
         in_data  = 60'(sent * 7 + 3);
         @(negedge Clk);
         checks++;
         if (in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_in_ready: got %b want 1 at cycle %0d", in_ready, cyc);
         end
         if (out_valid) begin
            checks++;
            exp = (q.size() != 0) ? q.pop_front() : '0;
            if (out_data !== exp) begin
               errors++; $display("FAIL b2b_data: got %h want %h", out_data, exp);
            end
            if (got == 63 || got == 64) begin
               checks++;
               if (out_data[5:0] !== ((got == 63) ? 6'd63 : 6'd0)) begin
                  errors++; $display("FAIL b2b_tag_wrap: word %0d got tag %0d", got, out_data[5:0]);
               end
            end
            got++;
         end
         if (in_valid && in_ready) begin
            q.push_back(model_frame(in_data, m_lfsr, m_tag));
            m_lfsr = lfsr_step(m_lfsr);
            m_tag  = m_tag + 6'd1;
            sent++;
         end
         @(posedge Clk);
         #1;
         cyc++;
      end
      in_valid = 1'b0;
      checks++;
      if (got != 70 || cyc != 72) begin
         errors++; $display("FAIL b2b_throughput: got %0d frames in %0d cycles want 70 in 72", got, cyc);
      end
   endtask

   task automatic test_reset_midstream();
      logic [77:0] f;
      logic [77:0] e;
      int lat;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 60'h111_1111_1111_1111;
      @(posedge Clk);
      #1;
      in_data = 60'h222_2222_2222_2222;
      @(posedge Clk);
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         errors++; $display("FAIL full_state: got in_ready %b out_valid %b want 0 1", in_ready, out_valid);
      end
      Rst       = 1'b1;
      out_ready = 1'b1;
      @(posedge Clk);
      #1;
      Rst      = 1'b0;
      in_valid = 1'b0;
      m_lfsr   = 11'h001;
      m_tag    = 6'd0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL flush: got out_valid %b in_ready %b want 0 1", out_valid, in_ready);
      end
      xfer(60'h0F0_F0F0_F0F0_F0F0, f, lat, e);
      checks++;
      if (f[16:6] !== 11'h001 || f[5:0] !== 6'd0) begin
         errors++; $display("FAIL post_reset_key_tag: got key %h tag %0d want 001 tag 0", f[16:6], f[5:0]);
      end
      checks++;
      if (f !== e) begin
         errors++; $display("FAIL post_reset_frame: got %h want %h", f, e);
      end
   endtask

   initial begin
      test_reset();
      test_first_words();
      test_carry();
      test_random_stream();
      test_back_to_back();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
